// File: rtl/fft_twiddle_sched.sv
// Per-stage twiddle scheduler for a parallel radix-2 FFT: tracks each beat's
// position within the frame and emits per-lane twiddle exponents and bypass flags.
module fft_twiddle_sched #(
  parameter int NPOINT = 128,
  parameter int LOGN   = 7,
  parameter int NPAR   = 4,
  parameter int STAGE  = 0,
  parameter int EXPW   = LOGN - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sop,
  output logic [NPAR*EXPW-1:0] coeff_exp,
  output logic [NPAR-1:0]      bypass,
  output logic                 out_valid,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic                 busy,
  output logic                 sop_err
);

  localparam int B      = NPOINT / NPAR;
  localparam int CNTW   = (B > 1) ? $clog2(B) : 1;
  localparam int LOGPAR = $clog2(NPAR);

  localparam logic [31:0]     MMASK = 32'((NPOINT >> STAGE) - 1);
  localparam logic [31:0]     HALF  = 32'(NPOINT >> (STAGE + 1));
  localparam logic [CNTW-1:0] LAST  = CNTW'(B - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_nxt;
  logic [CNTW-1:0]      cnt, cnt_nxt, beat_cnt;
  logic                 accept, last, err;
  logic [NPAR*EXPW-1:0] exp_nxt;
  logic [NPAR-1:0]      byp_nxt;

  // k = cnt*NPAR + lane as a concatenation; the upper half of each sub-block
  // gets exponent (p - M/2) scaled by 2^STAGE.
  function automatic logic [EXPW-1:0] lane_exp(input logic [CNTW-1:0] c,
                                               input logic [31:0]     lane);
    logic [31:0] k, p, e;
    k = (32'(c) << LOGPAR) | lane;
    p = k & MMASK;
    e = (p >= HALF) ? ((p - HALF) << STAGE) : 32'd0;
    return e[EXPW-1:0];
  endfunction

  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    exp_nxt   = '0;
    byp_nxt   = '0;
    accept    = in_valid && (in_sop || (state == RUN));
    beat_cnt  = in_sop ? '0 : cnt;
    last      = (beat_cnt == LAST);
    err       = in_valid && in_sop && (state == RUN) && (cnt != '0);

    if (accept) begin
      if (last) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        state_nxt = RUN;
        cnt_nxt   = beat_cnt + CNTW'(1);
      end
    end

    for (int l = 0; l < NPAR; l++) begin
      exp_nxt[l*EXPW +: EXPW] = lane_exp(beat_cnt, 32'(l));
      byp_nxt[l]              = (exp_nxt[l*EXPW +: EXPW] == '0);
    end
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      coeff_exp <= '0;
      bypass    <= '1;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      busy      <= 1'b0;
      sop_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      out_valid <= accept;
      out_sop   <= accept && in_sop;
      out_eop   <= accept && last;
      sop_err   <= err;
      // Busy covers the eop beat's output cycle too, but never a one-beat frame.
      busy      <= (state_nxt == RUN) || (accept && last && !in_sop);
      if (accept) begin
        coeff_exp <= exp_nxt;
        bypass    <= byp_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fft_twiddle_sched.sv
// Directed bench for fft_twiddle_sched: three stage instances share the beat
// stream; a scoreboard queue holds the expected output for each driven cycle.
module tb_fft_twiddle_sched;

  localparam int NPOINT = 128;
  localparam int NPAR   = 4;
  localparam int EXPW   = 6;
  localparam int B      = NPOINT / NPAR;
  localparam int NST    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_sop = 1'b0;

  logic [NPAR*EXPW-1:0] coeff [NST];
  logic [NPAR-1:0]      byp   [NST];
  logic                 ov    [NST];
  logic                 osop  [NST];
  logic                 oeop  [NST];
  logic                 obusy [NST];
  logic                 oerr  [NST];

  int stage_of [NST] = '{0, 1, 6};

  always #5 clk = ~clk;

  fft_twiddle_sched #(.NPOINT(128), .LOGN(7), .NPAR(4), .STAGE(0), .EXPW(6)) u_s0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop),
    .coeff_exp(coeff[0]), .bypass(byp[0]), .out_valid(ov[0]), .out_sop(osop[0]),
    .out_eop(oeop[0]), .busy(obusy[0]), .sop_err(oerr[0]));

  fft_twiddle_sched #(.NPOINT(128), .LOGN(7), .NPAR(4), .STAGE(1), .EXPW(6)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop),
    .coeff_exp(coeff[1]), .bypass(byp[1]), .out_valid(ov[1]), .out_sop(osop[1]),
    .out_eop(oeop[1]), .busy(obusy[1]), .sop_err(oerr[1]));

  fft_twiddle_sched #(.NPOINT(128), .LOGN(7), .NPAR(4), .STAGE(6), .EXPW(6)) u_s6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop),
    .coeff_exp(coeff[2]), .bypass(byp[2]), .out_valid(ov[2]), .out_sop(osop[2]),
    .out_eop(oeop[2]), .busy(obusy[2]), .sop_err(oerr[2]));

  typedef struct {
    bit valid;
    int cnt;
    bit sop;
    bit eop;
    bit err;
    bit busy;
  } exp_t;

  exp_t q[$];

  int  passed = 0;
  int  failed = 0;
  int  total  = 0;
  bit  m_run  = 0;
  int  m_cnt  = 0;
  int  pulses = 0;
  logic [NPAR*EXPW-1:0] last_coeff [NST];
  logic [NPAR-1:0]      last_byp   [NST];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference exponent from the plain index formula, written with % and *.
  function automatic int ref_exp(input int stage, input int k);
    int m, p;
    m = NPOINT >> stage;
    p = k % m;
    if (p < m / 2) return 0;
    return ((p - m / 2) * (1 << stage)) % (1 << EXPW);
  endfunction

  task automatic check_out();
    exp_t e;
    logic [NPAR*EXPW-1:0] ec;
    logic [NPAR-1:0]      eb;
    int x;
    if (q.size() == 0) begin
      chk("scoreboard_empty", 64'(q.size()), 64'd1);
      return;
    end
    e = q.pop_front();
    for (int s = 0; s < NST; s++) begin
      if (e.valid) begin
        for (int l = 0; l < NPAR; l++) begin
          x = ref_exp(stage_of[s], e.cnt * NPAR + l);
          ec[l*EXPW +: EXPW] = EXPW'(x);
          eb[l] = (x == 0);
        end
        last_coeff[s] = ec;
        last_byp[s]   = eb;
      end
      chk($sformatf("s%0d_out_valid", stage_of[s]), 64'(ov[s]), 64'(e.valid));
      chk($sformatf("s%0d_out_sop", stage_of[s]), 64'(osop[s]), 64'(e.sop));
      chk($sformatf("s%0d_out_eop", stage_of[s]), 64'(oeop[s]), 64'(e.eop));
      chk($sformatf("s%0d_sop_err", stage_of[s]), 64'(oerr[s]), 64'(e.err));
      chk($sformatf("s%0d_busy", stage_of[s]), 64'(obusy[s]), 64'(e.busy));
      chk($sformatf("s%0d_coeff_exp cnt%0d", stage_of[s], e.cnt), 64'(coeff[s]), 64'(last_coeff[s]));
      chk($sformatf("s%0d_bypass cnt%0d", stage_of[s], e.cnt), 64'(byp[s]), 64'(last_byp[s]));
    end
    if (ov[0] === 1'b1) pulses++;
  endtask

  // Drive one cycle, push the model's expectation, sample #1 after the edge.
  task automatic drive(input bit v, input bit s, input bit r);
    exp_t e;
    int c;
    rst = r; in_valid = v; in_sop = s;
    e = '{valid: 0, cnt: 0, sop: 0, eop: 0, err: 0, busy: 0};
    if (r) begin
      m_run = 0; m_cnt = 0;
      for (int i = 0; i < NST; i++) begin
        last_coeff[i] = '0;
        last_byp[i]   = '1;
      end
    end else if (v && (s || m_run)) begin
      c = s ? 0 : m_cnt;
      e.valid = 1; e.cnt = c; e.sop = s; e.err = s && m_run; e.eop = (c == B - 1);
      if (e.eop) begin m_run = 0; m_cnt = 0; end
      else begin m_run = 1; m_cnt = c + 1; end
      e.busy = m_run || (e.eop && !s);
    end else begin
      e.busy = m_run;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    // Reset values.
    drive(0, 0, 1);
    drive(0, 0, 1);

    // Non-sop beat and valid-less sop are ignored in IDLE.
    drive(1, 0, 0);
    drive(0, 1, 0);

    // Gapless frame, directly followed by a frame with valid on alternate cycles
    // (gap cycles also carry a stray in_sop without in_valid).
    for (int i = 0; i < B; i++) drive(1, i == 0, 0);
    pulses = 0;
    for (int i = 0; i < B; i++) begin
      drive(1, i == 0, 0);
      drive(0, 1, 0);
    end
    chk("gap_pulse_count", 64'(pulses), 64'(B));
    drive(0, 0, 0);

    // Restart at beat 10; eop must come 31 beats after the restart beat.
    for (int i = 0; i < 10; i++) drive(1, i == 0, 0);
    drive(1, 1, 0);
    for (int i = 1; i < B; i++) drive(1, 0, 0);
    drive(0, 0, 0);

    // Reset at beat 20, then a stray non-sop beat, then a clean frame.
    for (int i = 0; i < 20; i++) drive(1, i == 0, 0);
    drive(1, 0, 1);
    drive(1, 0, 0);
    for (int i = 0; i < B; i++) drive(1, i == 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
